// File: rtl/bidir_port_pkg.sv
// Shared constants for the bidirectional port controller: register offsets,
// turnaround FSM encoding and the turnaround counter width.
package bidir_port_pkg;

   localparam logic [7:0] OFS_DATA_OUT = 8'd0;
   localparam logic [7:0] OFS_DIR      = 8'd1;
   localparam logic [7:0] OFS_DATA_IN  = 8'd2;
   localparam logic [7:0] OFS_EDGE     = 8'd3;
   localparam logic [7:0] OFS_INT_MASK = 8'd4;

   // Wide enough for TURN_CYCLES up to 15.
   localparam int CNT_W = 4;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_TURN = 1'b1
   } state_t;

endpackage

// File: rtl/bidir_sync.sv
// WIDTH-bit, SYNC_STAGES-deep synchroniser for the asynchronous pad readback.
// Exposes the last two stages so the parent can detect edges.
module bidir_sync #(
   parameter int WIDTH       = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q_last,
   output logic [WIDTH-1:0] q_prev
);

   logic [WIDTH-1:0] stg [SYNC_STAGES];

   // NOTE: every stage is reset so no X can reach the edge compare after reset.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < SYNC_STAGES; i++) stg[i] <= '0;
      end else begin
         // NOTE: non-blocking assignments make this a true shift chain, not a wire.
         stg[0] <= d;
         for (int i = 1; i < SYNC_STAGES; i++) stg[i] <= stg[i-1];
      end
   end

   assign q_last = stg[SYNC_STAGES-1];
   assign q_prev = stg[SYNC_STAGES-2];

endmodule

// File: rtl/bidir_port_ctrl.sv
// PicoBlaze-facing bidirectional port controller with bus-turnaround delay.
// Define BIDIR_PORT_INT_EN to add the INT_MASK register and interrupt output.
module bidir_port_ctrl
   import bidir_port_pkg::*;
#(
   parameter int          WIDTH       = 8,
   parameter logic [7:0]  BASE_ADDR   = 8'h40,
   parameter int          TURN_CYCLES = 2,
   parameter int          SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [7:0]       port_id,
   input  logic             write_strobe,
   input  logic             read_strobe,
   input  logic [7:0]       out_port,
   output logic [7:0]       in_port,
   output logic [WIDTH-1:0] pad_o,
   output logic [WIDTH-1:0] pad_t,
   input  logic [WIDTH-1:0] pad_i
`ifdef BIDIR_PORT_INT_EN
   ,
   output logic             interrupt
`endif
);

   localparam logic [CNT_W-1:0] TURN_LOAD = CNT_W'(TURN_CYCLES);
   localparam logic [2:0]       WARM_LEN  = 3'(SYNC_STAGES + 1);

   logic [7:0]       ofs;
   logic             wr_data_out, wr_dir, wr_edge;
   logic [WIDTH-1:0] data_out, dir, pending, edge_flags;
   logic [WIDTH-1:0] dir_nxt, new_drive, edge_set, edge_clr;
   logic [WIDTH-1:0] sync_last, sync_prev;
   logic [CNT_W-1:0] turn_cnt;
   logic [2:0]       warm_cnt;
   logic             warm_done;
   logic [7:0]       rd_data;
   state_t           state;
   logic             unused_ok;

   assign unused_ok = &{1'b0, read_strobe, out_port};

   // Offset wraps modulo 256, so only BASE_ADDR..BASE_ADDR+4 hit a register.
   assign ofs         = port_id - BASE_ADDR;
   assign wr_data_out = write_strobe && (ofs == OFS_DATA_OUT);
   assign wr_dir      = write_strobe && (ofs == OFS_DIR);
   assign wr_edge     = write_strobe && (ofs == OFS_EDGE);

   assign dir_nxt   = wr_dir ? out_port[WIDTH-1:0] : dir;
   assign new_drive = dir_nxt & ~dir;

   bidir_sync #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk     (clk),
      .reset_n (reset_n),
      .d       (pad_i),
      .q_last  (sync_last),
      .q_prev  (sync_prev)
   );

   assign warm_done = (warm_cnt == WARM_LEN);
   assign edge_set  = warm_done ? ((sync_prev ^ sync_last) & ~dir) : '0;
   assign edge_clr  = wr_edge ? out_port[WIDTH-1:0] : '0;
   assign pad_o     = data_out;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         data_out <= '0;
         dir      <= '0;
         pending  <= '0;
         pad_t    <= '1;
         turn_cnt <= '0;
         state    <= ST_IDLE;
      end else begin
         if (wr_data_out) data_out <= out_port[WIDTH-1:0];
         dir <= dir_nxt;
         // Releases take effect now; a drive needs the old dir and a cleared pending bit.
         pad_t <= ~(dir_nxt & dir & ~pending);
         case (state)
            ST_IDLE: begin
               if (wr_dir && |new_drive) begin
                  pending  <= new_drive;
                  turn_cnt <= TURN_LOAD;
                  state    <= ST_TURN;
               end
            end
            ST_TURN: begin
               if (wr_dir) begin
                  pending  <= (pending | new_drive) & dir_nxt;
                  turn_cnt <= TURN_LOAD;
               end else if (turn_cnt == CNT_W'(1)) begin
                  pending  <= '0;
                  turn_cnt <= '0;
                  state    <= ST_IDLE;
               end else begin
                  turn_cnt <= turn_cnt - CNT_W'(1);
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Set wins over a simultaneous write-one-to-clear.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         edge_flags <= '0;
         warm_cnt   <= '0;
      end else begin
         if (!warm_done) warm_cnt <= warm_cnt + 3'd1;
         edge_flags <= (edge_flags & ~edge_clr) | edge_set;
      end
   end

`ifdef BIDIR_PORT_INT_EN
   logic [WIDTH-1:0] int_mask;
   logic             wr_mask;

   assign wr_mask = write_strobe && (ofs == OFS_INT_MASK);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         int_mask  <= '0;
         interrupt <= 1'b0;
      end else begin
         if (wr_mask) int_mask <= out_port[WIDTH-1:0];
         interrupt <= |(edge_flags & int_mask);
      end
   end
`endif

   always_comb begin
      // NOTE: default first so every path assigns rd_data and no latch is inferred.
      rd_data = '0;
      case (ofs)
         OFS_DATA_OUT: rd_data[WIDTH-1:0] = data_out;
         OFS_DIR:      rd_data[WIDTH-1:0] = dir;
         OFS_DATA_IN:  rd_data[WIDTH-1:0] = sync_last;
         OFS_EDGE:     rd_data[WIDTH-1:0] = edge_flags;
`ifdef BIDIR_PORT_INT_EN
         OFS_INT_MASK: rd_data[WIDTH-1:0] = int_mask;
`endif
         default:      rd_data = '0;
      endcase
   end

   assign in_port = rd_data;

endmodule

// File: tb/tb_bidir_port_ctrl.sv
// Directed, table-driven bench for bidir_port_ctrl (default parameters).
// Interrupt checks are compiled in when BIDIR_PORT_INT_EN is defined.
module tb_bidir_port_ctrl;

   logic       clk = 1'b0;
   logic       reset_n;
   logic [7:0] port_id;
   logic       write_strobe;
   logic       read_strobe;
   logic [7:0] out_port;
   logic [7:0] in_port;
   logic [7:0] pad_o;
   logic [7:0] pad_t;
   logic [7:0] pad_i;
`ifdef BIDIR_PORT_INT_EN
   logic       interrupt;
   localparam logic [7:0] MASK_RD = 8'h80;
`else
   localparam logic [7:0] MASK_RD = 8'h00;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   bidir_port_ctrl dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .port_id      (port_id),
      .write_strobe (write_strobe),
      .read_strobe  (read_strobe),
      .out_port     (out_port),
      .in_port      (in_port),
      .pad_o        (pad_o),
      .pad_t        (pad_t),
      .pad_i        (pad_i)
`ifdef BIDIR_PORT_INT_EN
      ,
      .interrupt    (interrupt)
`endif
   );

   typedef struct {
      logic       wr;
      logic [7:0] addr;
      logic [7:0] wdata;
      logic [7:0] exp_rd;
      logic [7:0] exp_pad_o;
      logic [7:0] exp_pad_t;
   } vec_t;

   vec_t vecs [10];

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [7:0] addr, input logic [7:0] data);
      port_id      = addr;
      out_port     = data;
      write_strobe = 1'b1;
      tick();
      write_strobe = 1'b0;
   endtask

   task automatic read_chk(input string name, input logic [7:0] addr, input logic [7:0] exp);
      port_id      = addr;
      write_strobe = 1'b0;
      #1;
      check(name, in_port, exp);
   endtask

   initial begin
      vecs[0] = '{1'b1, 8'h40, 8'hA5, 8'hA5,   8'hA5, 8'hFF};
      vecs[1] = '{1'b0, 8'h42, 8'h00, 8'hFF,   8'hA5, 8'hFF};
      vecs[2] = '{1'b0, 8'h43, 8'h00, 8'h00,   8'hA5, 8'hFF};
      vecs[3] = '{1'b1, 8'h44, 8'h80, MASK_RD, 8'hA5, 8'hFF};
      vecs[4] = '{1'b1, 8'h45, 8'h77, 8'h00,   8'hA5, 8'hFF};
      vecs[5] = '{1'b0, 8'h3F, 8'h00, 8'h00,   8'hA5, 8'hFF};
      vecs[6] = '{1'b1, 8'h40, 8'h3C, 8'h3C,   8'h3C, 8'hFF};
      vecs[7] = '{1'b1, 8'h41, 8'h00, 8'h00,   8'h3C, 8'hFF};
      vecs[8] = '{1'b1, 8'h43, 8'hFF, 8'h00,   8'h3C, 8'hFF};
      vecs[9] = '{1'b1, 8'h40, 8'hA5, 8'hA5,   8'hA5, 8'hFF};

      reset_n      = 1'b0;
      port_id      = 8'h00;
      write_strobe = 1'b0;
      read_strobe  = 1'b0;
      out_port     = 8'h00;
      pad_i        = 8'hFF;

      // Reset state and synchroniser latency.
      repeat (2) tick();
      check("rst_pad_t", pad_t, 8'hFF);
      check("rst_pad_o", pad_o, 8'h00);
      read_chk("rst_dir", 8'h41, 8'h00);
`ifdef BIDIR_PORT_INT_EN
      check("rst_irq", {7'd0, interrupt}, 8'h00);
`endif
      @(negedge clk);
      reset_n = 1'b1;
      tick();
      read_chk("sync_1cyc", 8'h42, 8'h00);
      tick();
      read_chk("sync_2cyc", 8'h42, 8'hFF);
      repeat (3) tick();
      read_chk("warmup_edge", 8'h43, 8'h00);

      // Register map vectors.
      for (int i = 0; i < 10; i++) begin
         port_id      = vecs[i].addr;
         out_port     = vecs[i].wdata;
         write_strobe = vecs[i].wr;
         tick();
         write_strobe = 1'b0;
         read_chk($sformatf("vec%0d_rd", i), vecs[i].addr, vecs[i].exp_rd);
         check($sformatf("vec%0d_pad_o", i), pad_o, vecs[i].exp_pad_o);
         check($sformatf("vec%0d_pad_t", i), pad_t, vecs[i].exp_pad_t);
      end

      // Basic turnaround: pad_t falls on the third edge after the write.
      wr(8'h41, 8'h0F);
      check("turn_e0", pad_t, 8'hFF);
      check("turn_pad_o", pad_o, 8'hA5);
      tick(); check("turn_e1", pad_t, 8'hFF);
      tick(); check("turn_e2", pad_t, 8'hFF);
      tick(); check("turn_e3", pad_t, 8'hF0);
      read_chk("turn_dir", 8'h41, 8'h0F);
      wr(8'h41, 8'h00);
      check("release_all", pad_t, 8'hFF);
      tick();

      // Restart: second DIR write while the counter sits at 1.
      wr(8'h41, 8'h0F);
      check("rst_e0", pad_t, 8'hFF);
      tick();
      wr(8'h41, 8'h03);
      check("restart_w", pad_t, 8'hFF);
      read_chk("restart_dir", 8'h41, 8'h03);
      tick(); check("restart_e1", pad_t, 8'hFF);
      tick(); check("restart_e2", pad_t, 8'hFF);
      tick(); check("restart_e3", pad_t, 8'hFC);

      // Mixed write: bit0 released at once, bit1 held, bits 3:2 wait.
      wr(8'h41, 8'h0E);
      check("mixed_e0", pad_t, 8'hFD);
      tick(); check("mixed_e1", pad_t, 8'hFD);
      tick(); check("mixed_e2", pad_t, 8'hFD);
      tick(); check("mixed_e3", pad_t, 8'hF1);
      wr(8'h41, 8'h00);
      check("mixed_rel", pad_t, 8'hFF);
      tick();

      // Edge detection and interrupt.
      pad_i = 8'h7F;
      tick(); read_chk("edge_e1", 8'h43, 8'h00);
      tick(); read_chk("edge_e2", 8'h43, 8'h80);
`ifdef BIDIR_PORT_INT_EN
      check("irq_pre", {7'd0, interrupt}, 8'h00);
`endif
      wr(8'h43, 8'h80);
      read_chk("w1c", 8'h43, 8'h00);
`ifdef BIDIR_PORT_INT_EN
      check("irq_set", {7'd0, interrupt}, 8'h01);
`endif
      tick();
`ifdef BIDIR_PORT_INT_EN
      check("irq_drop", {7'd0, interrupt}, 8'h00);
`endif
      pad_i = 8'hFF;
      tick(); tick();
      read_chk("edge_rise", 8'h43, 8'h80);
      pad_i = 8'h7F;
      tick();
      wr(8'h43, 8'h80);
      read_chk("set_beats_clr", 8'h43, 8'h80);
      wr(8'h43, 8'h80);
      read_chk("w1c_again", 8'h43, 8'h00);

      // Driven bits ignore edges.
      wr(8'h41, 8'h80);
      pad_i = 8'hFF;
      repeat (3) tick();
      read_chk("driven_noedge", 8'h43, 8'h00);
      wr(8'h41, 8'h00);
      tick();
      read_chk("released_noedge", 8'h43, 8'h00);

      // Reset in the middle of a turnaround.
      wr(8'h41, 8'h0F);
      tick();
      #2 reset_n = 1'b0;
      #1;
      check("midturn_pad_t", pad_t, 8'hFF);
      check("midturn_pad_o", pad_o, 8'h00);
      @(negedge clk);
      reset_n = 1'b1;
      read_chk("midturn_dir", 8'h41, 8'h00);
      repeat (4) tick();
      read_chk("midturn_edge", 8'h43, 8'h00);
      wr(8'h41, 8'h0F);
      check("post_e0", pad_t, 8'hFF);
      tick(); check("post_e1", pad_t, 8'hFF);
      tick(); check("post_e2", pad_t, 8'hFF);
      tick(); check("post_e3", pad_t, 8'hF0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
